mux_arbiter2: RTL and testbench
===============================

MUX_ARBITER2 -- requirements
Module: mux_arbiter2

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, as the data width of each requester and of the output.
REQ-002 The block SHALL provide parameter MAX_BURST, default 4, as the maximum beats per grant when burst limiting is compiled in; legal range 1..255.
REQ-003 Port list: Clock  input  1  sole clock, rising edge.
REQ-004 Port list: Reset  input  1  asynchronous, active-high reset.
REQ-005 Port list: Req0, Req1  input  1 each  requester i has a beat to send.
REQ-006 Port list: Input0, Input1  input  WIDTH each  requester data, held stable while Req is high.
REQ-007 Port list: Ack0, Ack1  output  1 each  beat from requester i accepted this cycle.
REQ-008 Port list: Selector  output  1  current mux select, 1 = requester 1 owns the datapath.
REQ-009 Port list: OutValid  output  1  output register holds a beat.
REQ-010 Port list: OutReady  input  1  downstream accepts the beat.
REQ-011 Port list: Output  output  WIDTH  registered output data.
REQ-012 Port list: OutSource  output  1  requester index of the beat in Output.

Function
REQ-013 The FSM SHALL have states IDLE, SERVE0 and SERVE1, held in a register.
REQ-014 Selector SHALL be 1 in SERVE1 and 0 in IDLE and SERVE0, driven from the state register only.
REQ-015 Define CanAccept = !OutValid | OutReady.
REQ-016 Acki SHALL be asserted combinationally when the state is SERVEi, Reqi=1 and CanAccept=1; it SHALL never be asserted in IDLE.
REQ-017 On Acki, Output SHALL load Inputi, OutSource SHALL load i and OutValid SHALL be 1 on the next edge.
REQ-018 If OutValid=1, OutReady=1 and no Ack is asserted, OutValid SHALL clear on the next edge.
REQ-019 When OutReady=1 and Acki=1 in the same cycle, OutValid SHALL remain 1 with the new beat (zero-bubble pass-through).
REQ-020 In IDLE with exactly one Reqi=1, the next state SHALL be SERVEi.
REQ-021 In IDLE with both requests high, the next state SHALL be SERVE of the requester not recorded in LastGrant.
REQ-022 Entering SERVEi SHALL set LastGrant=i and clear BeatCount.
REQ-023 On entering SERVEi, the grant SHALL be visible one cycle after the request.
REQ-024 The minimum latency from a Req rising in IDLE to OutValid SHALL be 2 cycles.
REQ-025 In SERVEi with Reqi=0, the next state SHALL be SERVEj if Reqj=1, else IDLE.
REQ-026 Each Acki SHALL increment BeatCount, saturating at MAX_BURST.
REQ-027 A beat pending while OutValid=1 and OutReady=0 SHALL stall: no Ack is asserted and the state and BeatCount hold.
REQ-028 Output and OutSource SHALL hold their value while OutValid=1 and OutReady=0.

Reset
REQ-029 While Reset=1, asynchronously:
- state=IDLE
- OutValid=0
- Output=0
- OutSource=0
- BeatCount=0
- LastGrant=1, so requester 0 wins the first contention.
REQ-030 A Reset asserted mid-burst or with OutValid=1 SHALL discard the held beat; no Ack SHALL be asserted during Reset.

Configuration
REQ-031 The block SHALL use the macro MUX_ARBITER2_BURST_LIMIT_EN.
REQ-032 With MUX_ARBITER2_BURST_LIMIT_EN defined, in SERVEi an Acki that brings BeatCount to MAX_BURST while Reqj=1 SHALL move the state to SERVEj on that edge.
REQ-033 With MUX_ARBITER2_BURST_LIMIT_EN defined and Reqj=0, the grant SHALL continue and BeatCount SHALL remain saturated.
REQ-034 Without MUX_ARBITER2_BURST_LIMIT_EN, the grant SHALL be held until Reqi drops, and BeatCount and MAX_BURST SHALL have no effect.

Verification
REQ-035 Single requester: Reset, then Req0=1 with Input0=8'h05 and OutReady=1 -> Selector=0, Ack0 in cycle 1, OutValid=1 with Output=8'h05 and OutSource=0 in cycle 2.
REQ-036 Contention from reset: Req0=Req1=1 in the same cycle -> SERVE0 first; after Req0 drops, SERVE1 with Selector=1.
REQ-037 Burst limit (macro defined, MAX_BURST=4): both requesters held high with OutReady=1 -> Output alternates 4 beats from requester 0 then 4 beats from requester 1, and Selector toggles every 4 beats.
REQ-038 No limit (macro undefined): same stimulus as REQ-037 -> only requester 0 is served until Req0 drops.
REQ-039 Backpressure: OutReady=0 for 3 cycles with OutValid=1 -> Ack stays 0 and Output is unchanged; on OutReady=1, pass-through occurs with no bubble.
REQ-040 Reset mid-burst: Reset pulsed after 2 beats -> OutValid=0, state=IDLE, and requester 0 wins the next contention.

Source files
------------

// File: rtl/mux_arbiter2.sv
// mux_arbiter2: two-requester round-robin mux with a registered output stage.
// A three-state FSM owns the datapath; grants move on request drop or,
// optionally, after MAX_BURST beats.
// Optional feature macro: MUX_ARBITER2_BURST_LIMIT_EN (burst limiting).
//
// state      | meaning
// -----------+---------------------------------------------
// ST_IDLE    | no owner, waiting for a request
// ST_SERVE0  | requester 0 owns the datapath
// ST_SERVE1  | requester 1 owns the datapath
module mux_arbiter2 #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] Input0,
    input  logic [WIDTH-1:0] Input1,
    output logic             Ack0,
    output logic             Ack1,
    output logic             Selector,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Output,
    output logic             OutSource
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SERVE0 = 2'd1;
    localparam logic [1:0] ST_SERVE1 = 2'd2;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("mux_arbiter2: MAX_BURST must be in 1..255");
    end

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             can_accept;
    logic             enter0, enter1;

`ifdef MUX_ARBITER2_BURST_LIMIT_EN
    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
    logic [7:0] beat_count_q, beat_count_d;
`endif

    // Handshake: acks come straight from the owner state and downstream space.
    always_comb begin
        can_accept = !out_valid_q || OutReady;
        Ack0       = (state_q == ST_SERVE0) && Req0 && can_accept;
        Ack1       = (state_q == ST_SERVE1) && Req1 && can_accept;
        Selector   = (state_q == ST_SERVE1);
        OutValid   = out_valid_q;
        Output     = out_data_q;
        OutSource  = out_src_q;
    end

    // Next owner: round-robin on contention, hand-off on request drop or burst end.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        enter0       = 1'b0;
        enter1       = 1'b0;
`ifdef MUX_ARBITER2_BURST_LIMIT_EN
        beat_count_d = beat_count_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // last_grant_q=1 means requester 0 is next in line.
                enter0 = Req0 && (!Req1 || last_grant_q);
                enter1 = Req1 && (!Req0 || !last_grant_q);
            end
            ST_SERVE0: begin
                if (!Req0) begin
                    enter1 = Req1;
                    if (!Req1) state_d = ST_IDLE;
                end else if (Ack0) begin
`ifdef MUX_ARBITER2_BURST_LIMIT_EN
                    if (beat_count_q != MAX_BURST_C) beat_count_d = beat_count_q + 8'd1;
                    enter1 = (beat_count_d == MAX_BURST_C) && Req1;
`endif
                end
            end
            ST_SERVE1: begin
                if (!Req1) begin
                    enter0 = Req0;
                    if (!Req0) state_d = ST_IDLE;
                end else if (Ack1) begin
`ifdef MUX_ARBITER2_BURST_LIMIT_EN
                    if (beat_count_q != MAX_BURST_C) beat_count_d = beat_count_q + 8'd1;
                    enter0 = (beat_count_d == MAX_BURST_C) && Req0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter0) begin
            state_d      = ST_SERVE0;
            last_grant_d = 1'b0;
`ifdef MUX_ARBITER2_BURST_LIMIT_EN
            beat_count_d = 8'd0;
`endif
        end else if (enter1) begin
            state_d      = ST_SERVE1;
            last_grant_d = 1'b1;
`ifdef MUX_ARBITER2_BURST_LIMIT_EN
            beat_count_d = 8'd0;
`endif
        end
    end

    // Output stage: load on ack, drain on ready, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (Ack0) begin
            out_valid_d = 1'b1;
            out_data_d  = Input0;
            out_src_d   = 1'b0;
        end else if (Ack1) begin
            out_valid_d = 1'b1;
            out_data_d  = Input1;
            out_src_d   = 1'b1;
        end else if (OutReady) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset discards any held beat.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
`ifdef MUX_ARBITER2_BURST_LIMIT_EN
            beat_count_q <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
`ifdef MUX_ARBITER2_BURST_LIMIT_EN
            beat_count_q <= beat_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_mux_arbiter2.sv
// Testbench for mux_arbiter2: vector table, directed corner sequences and a
// random run against a transaction-level reference model.
module tb_mux_arbiter2;

    localparam int W  = 8;
    localparam int MB = 4;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic         Req0 = 1'b0, Req1 = 1'b0, OutReady = 1'b0;
    logic [W-1:0] Input0 = '0, Input1 = '0;
    logic         Ack0, Ack1, Selector, OutValid, OutSource;
    logic [W-1:0] out_w;

    int total = 0;
    int bad   = 0;

    mux_arbiter2 #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .Clock(Clock), .Reset(Reset), .Req0(Req0), .Req1(Req1),
        .Input0(Input0), .Input1(Input1), .Ack0(Ack0), .Ack1(Ack1),
        .Selector(Selector), .OutValid(OutValid), .OutReady(OutReady),
        .Output(out_w), .OutSource(OutSource)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r0, input bit r1, input logic [W-1:0] d0,
                         input logic [W-1:0] d1, input bit rdy);
        @(posedge Clock);
        #1;
        Req0 = r0; Req1 = r1; Input0 = d0; Input1 = d1; OutReady = rdy;
    endtask

    task automatic do_reset();
        @(posedge Clock);
        #1;
        Reset = 1'b1; Req0 = 0; Req1 = 0; OutReady = 0; Input0 = '0; Input1 = '0;
        @(negedge Clock);
        check("rst_valid", OutValid, 0);
        check("rst_out", out_w, 0);
        check("rst_src", OutSource, 0);
        check("rst_sel", Selector, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // ---------------- reference model (owner / queue-free transaction view)
    int           m_owner;   // -1 none, else requester index
    int           m_last;
    int           m_beats;
    bit           m_valid;
    logic [W-1:0] m_out;
    int           m_src;

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_beats = 0; m_valid = 0; m_out = '0; m_src = 0;
    endtask

    function automatic bit model_ack(input int i, input bit ri, input bit rdy);
        return (m_owner == i) && ri && (!m_valid || rdy);
    endfunction

    task automatic model_step(input bit r0, input bit r1, input logic [W-1:0] d0,
                              input logic [W-1:0] d1, input bit rdy);
        bit           r[2];
        logic [W-1:0] d[2];
        bit           acked;
        int           grant;
        r[0] = r0; r[1] = r1; d[0] = d0; d[1] = d1;
        acked = 0;
        grant = -2;
        for (int i = 0; i < 2; i++) begin
            if (model_ack(i, r[i], rdy)) begin
                acked = 1; m_out = d[i]; m_src = i;
            end
        end
        if (acked) m_valid = 1;
        else if (rdy) m_valid = 0;
        if (m_owner < 0) begin
            if (r[0] && r[1]) grant = 1 - m_last;
            else if (r[0]) grant = 0;
            else if (r[1]) grant = 1;
        end else begin
            if (!r[m_owner]) begin
                grant = r[1 - m_owner] ? 1 - m_owner : -1;
            end else if (acked) begin
                m_beats = (m_beats + 1 > MB) ? MB : m_beats + 1;
`ifdef MUX_ARBITER2_BURST_LIMIT_EN
                if (m_beats == MB && r[1 - m_owner]) grant = 1 - m_owner;
`endif
            end
        end
        if (grant == -1) m_owner = -1;
        else if (grant >= 0) begin
            m_owner = grant; m_last = grant; m_beats = 0;
        end
    endtask

    // ---------------- vector table
    typedef struct {
        bit r0, r1; logic [W-1:0] d0, d1; bit rdy;
        bit a0, a1, sel, vld; logic [W-1:0] out; bit src;
    } vec_t;

    vec_t vecs[8];
    int   src_seq[16];

    initial begin
        // single requester, backpressure for 3 cycles, then zero-bubble pass-through
        vecs[0] = '{1, 0, 8'h05, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0};
        vecs[1] = '{1, 0, 8'h05, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0};
        vecs[2] = '{1, 0, 8'h06, 8'h00, 0, 0, 0, 0, 1, 8'h05, 0};
        vecs[3] = '{1, 0, 8'h06, 8'h00, 0, 0, 0, 0, 1, 8'h05, 0};
        vecs[4] = '{1, 0, 8'h06, 8'h00, 0, 0, 0, 0, 1, 8'h05, 0};
        vecs[5] = '{1, 0, 8'h06, 8'h00, 1, 1, 0, 0, 1, 8'h05, 0};
        vecs[6] = '{0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h06, 0};
        vecs[7] = '{0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1, vecs[i].rdy);
            @(negedge Clock);
            check($sformatf("vec%0d_ack0", i), Ack0, vecs[i].a0);
            check($sformatf("vec%0d_ack1", i), Ack1, vecs[i].a1);
            check($sformatf("vec%0d_sel", i), Selector, vecs[i].sel);
            check($sformatf("vec%0d_valid", i), OutValid, vecs[i].vld);
            if (vecs[i].vld) begin
                check($sformatf("vec%0d_out", i), out_w, vecs[i].out);
                check($sformatf("vec%0d_src", i), OutSource, vecs[i].src);
            end
        end

        // contention from reset: requester 0 first, then 1 after Req0 drops
        do_reset();
        drive(1, 1, 8'hA0, 8'hB0, 1);
        @(negedge Clock);
        check("cont_idle_ack0", Ack0, 0);
        check("cont_idle_ack1", Ack1, 0);
        drive(1, 1, 8'hA0, 8'hB0, 1);
        @(negedge Clock);
        check("cont_first_sel", Selector, 0);
        check("cont_first_ack0", Ack0, 1);
        check("cont_first_ack1", Ack1, 0);
        drive(0, 1, 8'hA0, 8'hB0, 1);
        @(negedge Clock);
        check("cont_drop_ack0", Ack0, 0);
        check("cont_drop_out", out_w, 8'hA0);
        check("cont_drop_src", OutSource, 0);
        drive(0, 1, 8'hA0, 8'hB0, 1);
        @(negedge Clock);
        check("cont_second_sel", Selector, 1);
        check("cont_second_ack1", Ack1, 1);
        drive(0, 0, 8'hA0, 8'hB0, 1);
        @(negedge Clock);
        check("cont_second_out", out_w, 8'hB0);
        check("cont_second_src", OutSource, 1);
        check("cont_second_valid", OutValid, 1);

        // both held high: burst alternation or single-owner hold
        do_reset();
        drive(1, 1, 8'h11, 8'h22, 1);
        @(negedge Clock);
        for (int k = 0; k < 16; k++) begin
            drive(1, 1, 8'h11, 8'h22, 1);
            @(negedge Clock);
            check($sformatf("burst%0d_one_ack", k), int'(Ack0) + int'(Ack1), 1);
            src_seq[k] = Ack1 ? 1 : 0;
`ifdef MUX_ARBITER2_BURST_LIMIT_EN
            check($sformatf("burst%0d_src", k), src_seq[k], (k / MB) % 2);
            check($sformatf("burst%0d_sel", k), Selector, (k / MB) % 2);
`else
            check($sformatf("burst%0d_src", k), src_seq[k], 0);
            check($sformatf("burst%0d_sel", k), Selector, 0);
`endif
        end

        // reset mid-burst discards the held beat and restores requester-0 priority
        do_reset();
        drive(1, 0, 8'h31, 8'h00, 1);
        drive(1, 0, 8'h32, 8'h00, 1);
        drive(1, 0, 8'h33, 8'h00, 1);
        @(negedge Clock);
        check("mid_pre_valid", OutValid, 1);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        Req1 = 1'b1;
        @(negedge Clock);
        check("mid_rst_ack0", Ack0, 0);
        check("mid_rst_ack1", Ack1, 0);
        check("mid_rst_valid", OutValid, 0);
        check("mid_rst_sel", Selector, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        check("mid_idle_ack0", Ack0, 0);
        drive(1, 1, 8'h44, 8'h55, 1);
        @(negedge Clock);
        check("mid_next_ack0", Ack0, 1);
        check("mid_next_ack1", Ack1, 0);
        check("mid_next_sel", Selector, 0);

        // random traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit           r0, r1, rdy;
            logic [W-1:0] d0, d1;
            r0  = ($urandom_range(0, 3) != 0);
            r1  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            d0  = W'($urandom);
            d1  = W'($urandom);
            drive(r0, r1, d0, d1, rdy);
            @(negedge Clock);
            check("rnd_ack0", Ack0, model_ack(0, r0, rdy));
            check("rnd_ack1", Ack1, model_ack(1, r1, rdy));
            check("rnd_sel", Selector, m_owner == 1);
            check("rnd_valid", OutValid, m_valid);
            if (m_valid) begin
                check("rnd_out", out_w, m_out);
                check("rnd_src", OutSource, m_src);
            end
            model_step(r0, r1, d0, d1, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
